// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_ctrl
//  Purpose  : Decode-stage branch resolution controller. Drives the D-stage
//             comparator opcode, stalls F/D until the branch source operands
//             can be forwarded, samples the comparator result on the resolve
//             cycle and issues a registered redirect to fetch. Also keeps
//             branch performance counters and a sticky wait-timeout flag.
//  Ports    :
//    clk, reset   - clock, synchronous active-high reset
//    BrValid      - compare-branch instruction present in D
//    CmpOpIn      - decoded compare opcode
//    RsReady      - rs is correct on the forwarded D bus this cycle
//    RtReady      - rt is correct on the forwarded D bus this cycle
//    BrTarget     - branch target of the instruction in D
//    Flush        - exception/eret flush, abandons a pending branch
//    Branch       - comparator result
//    CmpOp        - opcode to the comparator (000 = no compare)
//    Stall        - freeze F/D, bubble into E
//    Redirect     - one-cycle pulse: load RedirectPC, squash F
//    RedirectPC   - redirect target, valid while Redirect=1
//    BrCnt        - resolved branches
//    TakenCnt     - resolved taken branches
//    StallCnt     - cycles with Stall=1
//    Timeout      - sticky: a WAIT lasted MAX_WAIT stall cycles
//  Revision : 1.0  initial release
// ============================================================================
module branch_resolve_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             BrValid,
   input  logic [2:0]       CmpOpIn,
   input  logic             RsReady,
   input  logic             RtReady,
   input  logic [31:0]      BrTarget,
   input  logic             Flush,
   input  logic             Branch,
   output logic [2:0]       CmpOp,
   output logic             Stall,
   output logic             Redirect,
   output logic [31:0]      RedirectPC,
   output logic [CNT_W-1:0] BrCnt,
   output logic [CNT_W-1:0] TakenCnt,
   output logic [CNT_W-1:0] StallCnt,
   output logic             Timeout
);

   // Compare opcode encoding shared with the decoder
   localparam logic [2:0] CMP_NONE = 3'b000;
   localparam logic [2:0] CMP_EQ   = 3'b001;
   localparam logic [2:0] CMP_NE   = 3'b010;

   localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t     state;
   logic [7:0] wait_cnt;
   logic [7:0] wait_inc;
   logic       need_rt;
   logic       ready;
   logic       resolve;

   // Only the equality compares read rt; single-operand compares ignore it.
   assign need_rt  = (CmpOpIn == CMP_EQ) | (CmpOpIn == CMP_NE);
   assign ready    = RsReady & (RtReady | ~need_rt);
   assign resolve  = BrValid & ready & ~Flush;

   assign CmpOp    = BrValid ? CmpOpIn : CMP_NONE;
   assign Stall    = BrValid & ~ready & ~Flush;

   assign wait_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         wait_cnt   <= 8'd0;
         Redirect   <= 1'b0;
         RedirectPC <= 32'd0;
         BrCnt      <= '0;
         TakenCnt   <= '0;
         StallCnt   <= '0;
         Timeout    <= 1'b0;
      end else begin
         // Redirect is a pure one-cycle echo of the resolve cycle; a flush in
         // the following cycle does not cancel it.
         Redirect <= resolve & Branch;
         if (resolve) begin
            RedirectPC <= BrTarget;
            BrCnt      <= BrCnt + CNT_ONE;
         end
         if (resolve & Branch)
            TakenCnt <= TakenCnt + CNT_ONE;
         if (Stall)
            StallCnt <= StallCnt + CNT_ONE;

         // Raised on the stall cycle that brings the wait counter to MAX_WAIT
         if ((state == ST_WAIT) && Stall && (wait_inc >= MAX_WAIT_C))
            Timeout <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (Stall) begin
                  state    <= ST_WAIT;
                  wait_cnt <= 8'd1;
               end else begin
                  wait_cnt <= 8'd0;
               end
            end
            ST_WAIT: begin
               // Flush, resolve and a vanished branch (protocol error) all
               // drop back to IDLE; only a continuing stall keeps waiting.
               if (Stall) begin
                  wait_cnt <= wait_inc;
               end else begin
                  state    <= ST_IDLE;
                  wait_cnt <= 8'd0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Decode-stage branch resolution controller. It sequences the D-stage comparator: it drives the comparator opcode, stalls the front end until the branch source operands are forwardable, and samples the comparator result on the resolve cycle. It issues a registered redirect (with target) to the fetch stage and keeps branch performance counters. It sits between the hazard/forwarding logic and the NPC/PC-select logic.

Parameters:
MAX_WAIT, 15, stall cycles in WAIT before Timeout is raised (1..255)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
BrValid  in  1  compare-branch instruction present in D
CmpOpIn  in  3  decoded compare opcode (header_ctrl encoding)
RsReady  in  1  rs value correct on forwarded D bus this cycle
RtReady  in  1  rt value correct on forwarded D bus this cycle
BrTarget  in  32  computed branch target for the instruction in D
Flush  in  1  exception/eret flush; abandons any pending branch
Branch  in  1  comparator result (comparator driven by CmpOp)
CmpOp  out  3  opcode to comparator
Stall  out  1  freeze F/D, bubble into E
Redirect  out  1  registered one-cycle pulse: load RedirectPC, squash F instruction
RedirectPC  out  32  registered target, valid when Redirect=1
BrCnt  out  CNT_W  resolved branches
TakenCnt  out  CNT_W  resolved taken branches
StallCnt  out  CNT_W  cycles with Stall=1
Timeout  out  1  sticky: a WAIT exceeded MAX_WAIT cycles

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. At reset: state=IDLE, Stall=0, Redirect=0, RedirectPC=0, all counters=0, Timeout=0, wait counter=0.
- needRt = (CmpOpIn==cmp_eq) | (CmpOpIn==cmp_ne). ready = RsReady & (RtReady | ~needRt).
- CmpOp = BrValid ? CmpOpIn : 3'b000, the no-compare code (combinational).
- resolve = BrValid & ready & ~Flush.
- FSM states: IDLE, WAIT.
  - IDLE: if resolve, stay in IDLE. If BrValid & ~ready & ~Flush, Stall=1 and go to WAIT with wait counter=1.
  - WAIT: Stall = ~ready. On resolve, go to IDLE. Otherwise stay and increment the wait counter, saturating at 255.
  - WAIT with BrValid=0: protocol error. Return to IDLE with no redirect.
- Stall is combinational: BrValid & ~ready & ~Flush, in either state.
- Resolve cycle:
  - Branch is sampled.
  - Next cycle: Redirect = sampled Branch, and RedirectPC = BrTarget of the resolve cycle.
  - Redirect is 0 in every other cycle.
  - Latency from resolve to Redirect is exactly 1 cycle; back-to-back resolves give back-to-back Redirect pulses.
- Flush has priority over everything:
  - State goes to IDLE, Stall=0, wait counter cleared.
  - No resolve occurs that cycle.
  - A Redirect already registered from the previous cycle still appears; it is not cancelled.
- Counters:
  - BrCnt += 1 on resolve.
  - TakenCnt += 1 on resolve & Branch.
  - StallCnt += 1 when Stall=1.
  - All wrap modulo 2^CNT_W.
- Timeout is set when the wait counter reaches MAX_WAIT while in WAIT and Stall=1. It stays set until reset and has no effect on control.
- Reset asserted mid-WAIT returns everything to reset values on that edge. No Redirect follows.

Test Plan:
1. Reset, then BrValid=1, CmpOpIn=cmp_eq, RsReady=RtReady=1, Branch=1, BrTarget=0x00003010 -> Stall=0; next cycle Redirect=1, RedirectPC=0x00003010; BrCnt=1, TakenCnt=1.
2. cmp_eq with RtReady=0 for 3 cycles, then 1, Branch=0 -> Stall=1 for 3 cycles, state WAIT, then IDLE; no Redirect; StallCnt=3, BrCnt=1, TakenCnt=0.
3. cmp_gez with RsReady=1, RtReady=0, Branch=1 -> no stall (rt not needed); Redirect pulse the next cycle.
4. Stalled cmp_ne with Flush=1 on the 2nd wait cycle -> Stall drops to 0 that cycle, state IDLE, no Redirect, BrCnt unchanged, StallCnt=1.
5. MAX_WAIT=4 with RsReady held 0 for 6 cycles -> Timeout rises on the 4th stall cycle and stays 1 after resolve; cleared only by reset.
6. Two consecutive taken branches, each ready, targets 0x100 and 0x200 -> Redirect high for 2 cycles, RedirectPC 0x100 then 0x200. Then reset in WAIT -> all outputs 0 on the next cycle.
